// File: rtl/fbcpu_boot_loader.sv
// Boot loader for the FB-CPU / blram pair: streams a length-prefixed image into
// blram from address 0 while holding the CPU in reset, then hands the RAM port to the CPU.
module fbcpu_boot_loader #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10,
  parameter int DEPTH         = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  input  logic [DATA_WIDTH-1:0]    i_data,
  output logic                     o_ready,
  input  logic                     i_reload,
  input  logic [ADDRESS_WIDTH-1:0] cpu_mar,
  input  logic [DATA_WIDTH-1:0]    cpu_mdr_in,
  input  logic                     cpu_ram_wr,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_data_in,
  output logic                     ram_we,
  output logic                     o_cpu_rst,
  output logic                     o_done,
  output logic                     o_err,
  output logic [ADDRESS_WIDTH:0]   o_count,
  output logic [2:0]               o_state
);

  localparam int CW = ADDRESS_WIDTH + 1;
  localparam logic [DATA_WIDTH-1:0] HDR_LO_MASK = DATA_WIDTH'((64'd1 << CW) - 64'd1);

  typedef enum logic [2:0] {
    S_HDR   = 3'd0,
    S_LOAD  = 3'd1,
    S_FLUSH = 3'd2,
    S_RUN   = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t                   r_state;
  logic [CW-1:0]            r_count;
  logic [CW-1:0]            r_len;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_data;
  logic                     r_we;
  logic                     r_ready;
  logic                     r_cpu_rst;
  logic                     r_done;
  logic                     r_err;

  logic                     w_xfer;
  logic [CW-1:0]            w_len;
  logic                     w_hdr_bad;
  logic                     w_last;
  logic                     w_run;

  // Handshake: a word moves on a rising edge where i_valid && o_ready; i_data is
  // only looked at on such an edge, and a transfer coinciding with i_reload is dropped.
  assign w_xfer    = i_valid && r_ready;
  assign w_len     = i_data[ADDRESS_WIDTH:0];
  assign w_hdr_bad = (|(i_data & ~HDR_LO_MASK)) || (w_len > CW'(DEPTH));
  assign w_last    = (r_count + CW'(1)) == r_len;
  assign w_run     = (r_state == S_RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_HDR;
      r_count   <= '0;
      r_len     <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_we      <= 1'b0;
      r_ready   <= 1'b1;
      r_cpu_rst <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else if (i_reload) begin
      r_state   <= S_HDR;
      r_count   <= '0;
      r_len     <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_we      <= 1'b0;
      r_ready   <= 1'b1;
      r_cpu_rst <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_HDR: begin
          r_we <= 1'b0;
          if (w_xfer) begin
            r_len   <= w_len;
            r_count <= '0;
            if (w_hdr_bad) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
              r_ready <= 1'b0;
            end else if (w_len == '0) begin
              r_state   <= S_RUN;
              r_ready   <= 1'b0;
              r_cpu_rst <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              r_state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          // Write is presented the cycle after the accept, at the pre-increment count.
          r_we <= w_xfer;
          if (w_xfer) begin
            r_addr  <= r_count[ADDRESS_WIDTH-1:0];
            r_data  <= i_data;
            r_count <= r_count + CW'(1);
            if (w_last) begin
              r_state <= S_FLUSH;
              r_ready <= 1'b0;
            end
          end
        end
        S_FLUSH: begin
          r_we      <= 1'b0;
          r_state   <= S_RUN;
          r_cpu_rst <= 1'b0;
          r_done    <= 1'b1;
        end
        S_RUN: r_we <= 1'b0;
        S_ERR: r_we <= 1'b0;
        default: begin
          r_state <= S_HDR;
          r_we    <= 1'b0;
        end
      endcase
    end
  end

  // Once running, the CPU owns blram with no added latency.
  assign ram_addr    = w_run ? cpu_mar    : r_addr;
  assign ram_data_in = w_run ? cpu_mdr_in : r_data;
  assign ram_we      = w_run ? cpu_ram_wr : r_we;

  assign o_ready   = r_ready;
  assign o_cpu_rst = r_cpu_rst;
  assign o_done    = r_done;
  assign o_err     = r_err;
  assign o_count   = r_count;
  assign o_state   = r_state;

endmodule

// File: doc/fbcpu_boot_loader.md
Name: fbcpu_boot_loader

Overview:
Upstream stage of the FB-CPU / blram pair. It receives a program image as a valid/ready word stream and writes it into blram starting at address 0, while holding the CPU in reset. After the image is loaded, it releases the CPU and passes the CPU's memory port (MAR/MDRIn/RAMWr) straight through to blram. This lets one bench load any test program at runtime, without per-test RAM init files.

Parameters:
ADDRESS_WIDTH, 6, blram address width.
DATA_WIDTH, 10, word width; must be ≥ ADDRESS_WIDTH+1.
DEPTH, 64, number of blram words; maximum image length.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
i_valid  in  1  stream word valid.
i_data  in  DATA_WIDTH  stream word.
o_ready  out  1  loader can accept a word.
i_reload  in  1  one-cycle pulse: re-enter load mode.
cpu_mar  in  ADDRESS_WIDTH  CPU MAR.
cpu_mdr_in  in  DATA_WIDTH  CPU write data (MDRIn).
cpu_ram_wr  in  1  CPU write enable (RAMWr).
ram_addr  out  ADDRESS_WIDTH  to blram i_addr.
ram_data_in  out  DATA_WIDTH  to blram i_ram_data_in.
ram_we  out  1  to blram i_we.
o_cpu_rst  out  1  active-high reset to FBCPU rst.
o_done  out  1  image loaded; CPU running.
o_err  out  1  bad header; sticky until reset or reload.
o_count  out  ADDRESS_WIDTH+1  words written in the current load.

Behaviour:
- A transfer occurs when i_valid && o_ready on a rising clk edge. i_data is sampled only on a transfer.
- FSM states: HDR, LOAD, FLUSH, RUN, ERR. Async reset (rst=0) forces HDR.
- Reset values: o_ready=1, o_cpu_rst=1, o_done=0, o_err=0, o_count=0, ram_we=0, ram_addr=0, ram_data_in=0.
- HDR: o_ready=1. The first transferred word is the length N = i_data[ADDRESS_WIDTH:0].
  - N=0 -> RUN.
  - 1≤N≤DEPTH -> LOAD.
  - N>DEPTH -> ERR.
  - Any nonzero bits of i_data above bit ADDRESS_WIDTH -> ERR.
- LOAD: o_ready=1. A word transferred in cycle t is written to blram in cycle t+1 via registered signals: ram_we=1, ram_addr=o_count (pre-increment), ram_data_in=word. o_count increments at the same edge. Consecutive transfers give back-to-back writes. When no transfer occurs, ram_we=0 in the next cycle. On the N-th transfer -> FLUSH.
- FLUSH: one cycle. o_ready=0. The last write is presented. Then -> RUN.
- RUN: o_ready=0, o_cpu_rst=0, o_done=1. ram_addr=cpu_mar, ram_data_in=cpu_mdr_in, ram_we=cpu_ram_wr, all combinational pass-through with zero latency. The loader never writes in RUN.
- o_cpu_rst is registered and is 1 in every state except RUN. The CPU therefore leaves reset on the first edge after RUN is entered, which is after the last image write has been clocked into blram.
- ERR: o_ready=0, o_err=1, o_cpu_rst=1, ram_we=0. The state is held until reset or i_reload.
- i_reload (any state): at the next edge go to HDR and clear o_count, o_done and o_err. Set o_cpu_rst=1 and ram_we=0. A transfer in the same cycle as i_reload is ignored.
- A mid-load reset (rst low during LOAD) aborts immediately. Words already written stay in blram. The loader restarts in HDR.
- The address never wraps: N≤DEPTH guarantees ram_addr ≤ DEPTH-1 during load.
- Memory is read by blram only. The loader needs no read path.

Test Plan:
1. Reset, then stream header 3 and words 0x101, 0x202, 0x3FF, one per cycle. Required: writes to addresses 0, 1, 2 in three consecutive cycles, one cycle after each accept. Then FLUSH, and o_cpu_rst falls 2 cycles after the last accept. blram.memory[0..2] = 0x101, 0x202, 0x3FF, and o_count=3.
2. Stream a header of 64 and 64 words with i_valid toggled randomly. Required: o_count=64, memory[63] holds the last word, and no write lands beyond address 63. Then load the TEST_CASE 2 program and run 10000 cycles. Required: memory[52]=50, matching the existing bench check.
3. Send header 0. Required: RUN is entered 1 cycle later, o_done=1, and ram_we=0 throughout.
4. Send header 65, then a separate run with header 0x080. Required: o_err=1, o_cpu_rst stays 1, o_ready=0, and no write occurs. Then pulse i_reload. Required: o_err=0 and o_ready=1.
5. In RUN, drive cpu_mar=52, cpu_mdr_in=15, cpu_ram_wr=1. Required: ram_addr, ram_data_in and ram_we equal these in the same cycle, and memory[52]=15.
6. Assert rst low after 5 of 10 words. Required: all outputs immediately take their reset values. Reload header 2 plus 2 words. Required: writes land at addresses 0 and 1.
